// File: rtl/addr_ext_pkg.sv
// -----------------------------------------------------------------------------
// addr_ext_pkg
// Shared definitions for the address/immediate extension pipeline:
//   - mode_e    : 2-bit extension mode selector
//   - MAX_SHIFT : largest supported scale shift
// -----------------------------------------------------------------------------
package addr_ext_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,
    MODE_SIGN   = 2'b01,
    MODE_SCALED = 2'b10,
    MODE_REL    = 2'b11
  } mode_e;

  localparam int MAX_SHIFT = 4;

endpackage

// File: rtl/addr_ext_stage.sv
// -----------------------------------------------------------------------------
// addr_ext_stage
// Generic valid/ready register slice (one pipeline stage).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_vld / in_rdy   : upstream handshake, in_data payload
//   out_vld / out_rdy : downstream handshake, out_data payload
// The slice loads whenever it is empty or its content is being taken, so
// in_rdy is combinational from out_rdy (this is what lets a full pipeline
// accept and drain in the same cycle).
// -----------------------------------------------------------------------------
module addr_ext_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data
);

  logic              vld_d, vld_q;
  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    in_rdy = !vld_q || out_rdy;
    vld_d  = vld_q;
    data_d = data_q;
    if (in_rdy) begin
      vld_d = in_vld;
      // Payload only moves with a real transfer, so a stalled result holds.
      if (in_vld) data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_vld  = vld_q;
  assign out_data = data_q;

endmodule

// File: rtl/addr_extend_pipe.sv
// -----------------------------------------------------------------------------
// addr_extend_pipe
// Two-stage pipelined immediate/address extension unit.
//   Modes: ZERO (zero-extend), SIGN (sign-extend), SCALED (zero-extend << SHIFT),
//          REL (base + (sign-extend << SHIFT)).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : request handshake; in_imm, in_mode, in_base payload
//   out_valid / out_ready : result handshake; out_addr, out_ovf payload
//   out_misalign          : only with ADDR_EXT_ALIGN_CHECK_EN defined; result
//                           has nonzero bits below the SHIFT alignment
// Optional feature macro: ADDR_EXT_ALIGN_CHECK_EN
// -----------------------------------------------------------------------------
module addr_extend_pipe
  import addr_ext_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [OUT_W-1:0] in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_addr,
  output logic             out_ovf
`ifdef ADDR_EXT_ALIGN_CHECK_EN
  ,
  output logic             out_misalign
`endif
);

  if (IN_W < 1 || IN_W >= OUT_W || SHIFT < 0 || SHIFT > MAX_SHIFT) begin : g_param_err
    $error("addr_extend_pipe: illegal parameters IN_W=%0d OUT_W=%0d SHIFT=%0d",
           IN_W, OUT_W, SHIFT);
  end

  // Wide enough that a shifted immediate never loses bits (IN_W+SHIFT <=
  // OUT_W+3), so both the scaled overflow and the REL sum are exact.
  localparam int WIDE_W = OUT_W + MAX_SHIFT + 1;
  localparam int P1_W   = WIDE_W + OUT_W + 2 + 1;
`ifdef ADDR_EXT_ALIGN_CHECK_EN
  localparam int P2_W   = OUT_W + 2;
  localparam logic [OUT_W-1:0] ALIGN_MASK = OUT_W'((64'd1 << SHIFT) - 64'd1);
`else
  localparam int P2_W   = OUT_W + 1;
`endif

  function automatic logic signed [WIDE_W-1:0] sext_imm(input logic [IN_W-1:0] imm);
    return {{(WIDE_W-IN_W){imm[IN_W-1]}}, imm};
  endfunction

  // Exact unsigned(base) + signed(off); the MSB of the return is set when the
  // true sum falls outside 0..2^OUT_W-1, the low bits are the wrapped sum.
  function automatic logic [OUT_W:0] rel_sum_wrap(input logic [OUT_W-1:0]        base,
                                                  input logic signed [WIDE_W-1:0] off);
    logic signed [WIDE_W:0] sum;
    sum = $signed({{(WIDE_W+1-OUT_W){1'b0}}, base}) + $signed({off[WIDE_W-1], off});
    return {|sum[WIDE_W:OUT_W], sum[OUT_W-1:0]};
  endfunction

  // ---- stage 1 input: extension ----
  logic signed [WIDE_W-1:0] ext_p0;
  logic [WIDE_W-1:0]        imm_zx_p0;
  logic                     pre_ovf_p0;

  always_comb begin
    imm_zx_p0  = WIDE_W'(in_imm);
    ext_p0     = imm_zx_p0;
    pre_ovf_p0 = 1'b0;
    case (mode_e'(in_mode))
      MODE_ZERO:   ext_p0 = imm_zx_p0;
      MODE_SIGN:   ext_p0 = sext_imm(in_imm);
      MODE_SCALED: begin
        ext_p0     = imm_zx_p0 << SHIFT;
        pre_ovf_p0 = |ext_p0[WIDE_W-1:OUT_W];
      end
      MODE_REL:    ext_p0 = sext_imm(in_imm) <<< SHIFT;
      default:     ext_p0 = imm_zx_p0;
    endcase
  end

  logic              vld_p1, rdy_p1;
  logic [P1_W-1:0]   data_p1;

  addr_ext_stage #(.DATA_W(P1_W)) u_stage1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_valid),
    .in_rdy   (in_ready),
    .in_data  ({ext_p0, in_base, in_mode, pre_ovf_p0}),
    .out_vld  (vld_p1),
    .out_rdy  (rdy_p1),
    .out_data (data_p1)
  );

  // ---- stage 2 input: base add and result select ----
  logic signed [WIDE_W-1:0] ext_p1;
  logic [OUT_W-1:0]         base_p1;
  logic [1:0]               mode_p1;
  logic                     pre_ovf_p1;
  logic [OUT_W-1:0]         res_addr_p1;
  logic                     res_ovf_p1;
  logic [P2_W-1:0]          res_p1;

  assign {ext_p1, base_p1, mode_p1, pre_ovf_p1} = data_p1;

  always_comb begin
    res_addr_p1 = ext_p1[OUT_W-1:0];
    res_ovf_p1  = pre_ovf_p1;
    if (mode_e'(mode_p1) == MODE_REL) begin
      {res_ovf_p1, res_addr_p1} = rel_sum_wrap(base_p1, ext_p1);
    end
  end

`ifdef ADDR_EXT_ALIGN_CHECK_EN
  logic res_mis_p1;
  // SCALED results are aligned by construction; forced low regardless.
  assign res_mis_p1 = (mode_e'(mode_p1) != MODE_SCALED) && |(res_addr_p1 & ALIGN_MASK);
  assign res_p1     = {res_mis_p1, res_ovf_p1, res_addr_p1};
`else
  assign res_p1     = {res_ovf_p1, res_addr_p1};
`endif

  logic [P2_W-1:0] data_p2;

  addr_ext_stage #(.DATA_W(P2_W)) u_stage2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (vld_p1),
    .in_rdy   (rdy_p1),
    .in_data  (res_p1),
    .out_vld  (out_valid),
    .out_rdy  (out_ready),
    .out_data (data_p2)
  );

  // ---- stage 2 output ----
`ifdef ADDR_EXT_ALIGN_CHECK_EN
  assign {out_misalign, out_ovf, out_addr} = data_p2;
`else
  assign {out_ovf, out_addr} = data_p2;
`endif

endmodule

// File: tb/tb_addr_extend_pipe.sv
module tb_addr_extend_pipe;
  import addr_ext_pkg::*;

  localparam int IN_W    = 12;
  localparam int OUT_W   = 32;
  localparam int SHIFT   = 2;
  localparam int N_OUT_W = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [IN_W-1:0]   in_imm;
  logic [1:0]        in_mode;
  logic [OUT_W-1:0]  in_base, out_addr;
  logic              mis_obs;

  logic              n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_out_ovf;
  logic [IN_W-1:0]   n_in_imm;
  logic [1:0]        n_in_mode;
  logic [N_OUT_W-1:0] n_in_base, n_out_addr;

`ifdef ADDR_EXT_ALIGN_CHECK_EN
  logic out_misalign, n_out_misalign;
  assign mis_obs = out_misalign;
`else
  assign mis_obs = 1'b0;
`endif

  addr_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_ovf(out_ovf)
`ifdef ADDR_EXT_ALIGN_CHECK_EN
    , .out_misalign(out_misalign)
`endif
  );

  addr_extend_pipe #(.IN_W(IN_W), .OUT_W(N_OUT_W), .SHIFT(SHIFT)) dut_n (
    .clk(clk), .rst_n(rst_n),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_imm(n_in_imm),
    .in_mode(n_in_mode), .in_base(n_in_base),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_addr(n_out_addr),
    .out_ovf(n_out_ovf)
`ifdef ADDR_EXT_ALIGN_CHECK_EN
    , .out_misalign(n_out_misalign)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]       mode;
    logic [IN_W-1:0]  imm;
    logic [OUT_W-1:0] base;
  } req_t;

  typedef struct packed {
    logic [OUT_W-1:0] addr;
    logic             ovf;
    logic             mis;
  } exp_t;

  exp_t exp_q[$];

  // Reference: exact integer value of the requested address, then wrap/flag.
  function automatic exp_t model(input int out_w, input req_t r);
    longint imm_u, imm_s, val, mask, scale;
    exp_t   e;
    imm_u = longint'(r.imm);
    imm_s = (imm_u >= (longint'(1) << (IN_W-1))) ? imm_u - (longint'(1) << IN_W) : imm_u;
    mask  = (longint'(1) << out_w) - 1;
    scale = longint'(1) << SHIFT;
    case (r.mode)
      2'b00:   val = imm_u;
      2'b01:   val = imm_s;
      2'b10:   val = imm_u * scale;
      default: val = longint'(r.base) + imm_s * scale;
    endcase
    e.addr = OUT_W'(val & mask);
    e.ovf  = (r.mode[1] == 1'b1) && (val < 0 || val > mask);
`ifdef ADDR_EXT_ALIGN_CHECK_EN
    e.mis  = (r.mode != 2'b10) && ((longint'(e.addr) % scale) != 0);
`else
    e.mis  = 1'b0;
`endif
    return e;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.mode = 2'($urandom_range(0, 3));
    r.imm  = IN_W'($urandom);
    case ($urandom_range(0, 3))
      0:       r.base = OUT_W'($urandom_range(0, 16));
      1:       r.base = 32'hFFFF_FFFF - OUT_W'($urandom_range(0, 16));
      default: r.base = OUT_W'($urandom);
    endcase
    return r;
  endfunction

  task automatic drive_req(input req_t r, input logic v);
    in_valid = v;
    in_mode  = r.mode;
    in_imm   = r.imm;
    in_base  = r.base;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1; n_out_ready = 1'b1;
    in_valid = 1'b0; in_imm = '0; in_mode = '0; in_base = '0;
    n_in_valid = 1'b0; n_in_imm = '0; n_in_mode = '0; n_in_base = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_addr, out_ovf, mis_obs} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b addr=%h ovf=%b mis=%b, required all zero",
               out_valid, out_addr, out_ovf, mis_obs);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic send_check(input string name, input logic [1:0] mode, input logic [IN_W-1:0] imm,
                            input logic [OUT_W-1:0] base, input logic [OUT_W-1:0] ea, input logic eo);
    req_t r;
    exp_t e;
    int   lat;
    r = '{mode: mode, imm: imm, base: base};
    e = model(OUT_W, r);
    @(negedge clk);
    out_ready = 1'b1;
    drive_req(r, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, required 2", name, lat);
    end
    checks++;
    if ({out_addr, out_ovf} !== {ea, eo}) begin
      errors++;
      $display("FAIL %s: got addr=%h ovf=%b, required addr=%h ovf=%b", name, out_addr, out_ovf, ea, eo);
    end
    checks++;
    if (mis_obs !== e.mis) begin
      errors++;
      $display("FAIL %s_misalign: got %b, required %b", name, mis_obs, e.mis);
    end
  endtask

  task automatic test_directed();
    send_check("zero_800",     2'b00, 12'h800, 32'h0,         32'h0000_0800, 1'b0);
    send_check("sign_800",     2'b01, 12'h800, 32'h0,         32'hFFFF_F800, 1'b0);
    send_check("sign_7ff",     2'b01, 12'h7FF, 32'h0,         32'h0000_07FF, 1'b0);
    send_check("scaled_abc",   2'b10, 12'hABC, 32'h0,         32'h0000_2AF0, 1'b0);
    send_check("rel_1000_m1",  2'b11, 12'hFFF, 32'h0000_1000, 32'h0000_0FFC, 1'b0);
    send_check("rel_2_m1",     2'b11, 12'hFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b1);
    send_check("rel_fffc_p1",  2'b11, 12'h001, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1);
    send_check("rel_max_p1",   2'b11, 12'h001, 32'hFFFF_FFFF, 32'h0000_0003, 1'b1);
    send_check("rel_0_m1",     2'b11, 12'hFFF, 32'h0000_0000, 32'hFFFF_FFFC, 1'b1);
    send_check("rel_minneg",   2'b11, 12'h800, 32'h0001_0000, 32'h0000_E000, 1'b0);
  endtask

  task automatic test_scaled_narrow();
    int lat;
    @(negedge clk);
    n_out_ready = 1'b1;
    n_in_valid = 1'b1; n_in_mode = 2'b10; n_in_imm = 12'hC00; n_in_base = '0;
    #1;
    checks++;
    if (n_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL narrow_in_ready: got %b, required 1", n_in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    n_in_valid = 1'b0;
    lat = 1;
    while (!n_out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if ({lat == 2, n_out_addr, n_out_ovf} !== {1'b1, 13'h1000, 1'b1}) begin
      errors++;
      $display("FAIL narrow_scaled_ovf: got lat=%0d addr=%h ovf=%b, required lat=2 addr=1000 ovf=1",
               lat, n_out_addr, n_out_ovf);
    end
  endtask

  task automatic pop_compare(input string name);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected: got addr=%h with no outstanding request, required none",
               name, out_addr);
    end else begin
      e = exp_q.pop_front();
      if ({out_addr, out_ovf, mis_obs} !== {e.addr, e.ovf, e.mis}) begin
        errors++;
        $display("FAIL %s: got addr=%h ovf=%b mis=%b, required addr=%h ovf=%b mis=%b",
                 name, out_addr, out_ovf, mis_obs, e.addr, e.ovf, e.mis);
      end
    end
  endtask

  task automatic test_random();
    req_t r;
    logic pend;
    pend = 1'b0;
    exp_q.delete();
    r = rand_req();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 99) < 70);
      if (!pend) begin
        r = rand_req();
        pend = ($urandom_range(0, 99) < 75);
      end
      drive_req(r, pend);
      #1;
      if (out_valid && out_ready) pop_compare("random");
      if (in_valid && in_ready) begin
        exp_q.push_back(model(OUT_W, r));
        pend = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (out_valid) pop_compare("random_drain");
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_lost: got %0d results missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    req_t reqs[4];
    int   idx, got;
    exp_q.delete();
    for (int i = 0; i < 4; i++) reqs[i] = rand_req();
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      if (idx < 4) drive_req(reqs[idx], 1'b1);
      #1;
      if (out_valid) begin
        checks++;
        if ({out_addr, out_ovf} !== {exp_q[0].addr, exp_q[0].ovf}) begin
          errors++;
          $display("FAIL bp_hold: got addr=%h ovf=%b, required addr=%h ovf=%b",
                   out_addr, out_ovf, exp_q[0].addr, exp_q[0].ovf);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(OUT_W, reqs[idx]));
        idx++;
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({idx == 2, in_ready, out_valid} !== 3'b101) begin
      errors++;
      $display("FAIL bp_stall: got accepted=%0d in_ready=%b out_valid=%b, required 2/0/1",
               idx, in_ready, out_valid);
    end
    got = 0;
    for (int c = 0; c < 20 && (got < 4 || idx < 4); c++) begin
      if (c > 0) @(negedge clk);
      out_ready = 1'b1;
      if (idx < 4) drive_req(reqs[idx], 1'b1);
      else in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        pop_compare("bp_drain");
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(OUT_W, reqs[idx]));
        idx++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (got !== 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_count: got %0d results (%0d pending), required 4 (0)", got, exp_q.size());
    end
  endtask

  task automatic test_reset_midop();
    req_t r;
    exp_t e;
    int   w;
    exp_q.delete();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      drive_req(rand_req(), 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_addr, out_ovf, mis_obs} !== '0) begin
      errors++;
      $display("FAIL midop_reset: got valid=%b addr=%h ovf=%b, required all zero",
               out_valid, out_addr, out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midop_ghost: got out_valid=%b after reset, required 0", out_valid);
      end
    end
    r = '{mode: 2'b11, imm: 12'h005, base: 32'h0000_0100};
    e = model(OUT_W, r);
    drive_req(r, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if ({out_valid, out_addr, out_ovf} !== {1'b1, e.addr, e.ovf}) begin
      errors++;
      $display("FAIL midop_first: got valid=%b addr=%h ovf=%b, required valid=1 addr=%h ovf=%b",
               out_valid, out_addr, out_ovf, e.addr, e.ovf);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_scaled_narrow();
    test_backpressure();
    test_random();
    test_reset_midop();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
